// File: rtl/mem_view_ctrl_pkg.sv
// Shared definitions for the memory-inspection controller.
// The default widths live here so the data memory, the display block and this
// controller all agree on the word and address sizes. The state encoding is
// shared so any debug probe can decode the controller state.
package mem_view_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_READ = 3'd2,
        S_WAIT = 3'd3,
        S_SHOW = 3'd4
    } state_t;

endpackage

// File: rtl/mem_view_ctrl_debounce.sv
// Input conditioner for one raw board input (switch or push button).
// A 2-FF synchroniser followed by a debouncer: the debounced level follows the
// synchronised level only after the two have differed for 2^DEB_CNT-1
// consecutive clk cycles; any bounce back restarts the count.
// Ports:
//   clk         board clock
//   rst         asynchronous, active-high reset (clears synchroniser and count)
//   din         raw asynchronous input
//   dout        debounced level
//   rise_pulse  one-cycle pulse, high in the first cycle dout reads 1
module mem_view_ctrl_debounce #(
    parameter int DEB_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise_pulse
);

    // The count value reached on the last of the 2^DEB_CNT-1 differing cycles.
    localparam logic [DEB_CNT-1:0] CNT_LAST = {{(DEB_CNT-1){1'b1}}, 1'b0};

    logic               sync_q1;
    logic               sync_q2;
    logic [DEB_CNT-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q1    <= din;
            sync_q2    <= sync_q1;
            rise_pulse <= 1'b0;
            if (sync_q2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                dout       <= sync_q2;
                rise_pulse <= sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_view_ctrl.sv
// Debug memory-inspection controller.
// On a view request it waits for the low phase of the slow CPU clock, freezes
// the CPU clock through read_mem_en, reads data memory through a spare read
// port and holds the captured word for the board display. A debounced button
// steps through addresses while the view is active.
// Ports:
//   clk          board clock (shared with the CPU clock adjuster)
//   rst          asynchronous, active-high reset
//   sw_view      raw switch, 1 = inspection mode requested
//   btn_next     raw push button, step to the next address
//   cpu_clk_lvl  current level of the slow CPU clock
//   read_mem_en  1 = hold the CPU clock frozen (flop output)
//   dbg_rd       one-cycle memory read strobe
//   dbg_addr     memory read address
//   dbg_rdata    memory read data, valid MEM_LAT cycles after dbg_rd
//   view_data    last captured word
//   view_valid   view_data belongs to dbg_addr
module mem_view_ctrl
    import mem_view_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEB_CNT = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_view,
    input  logic              btn_next,
    input  logic              cpu_clk_lvl,
    output logic              read_mem_en,
    output logic              dbg_rd,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic [DATA_W-1:0] view_data,
    output logic              view_valid
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        lat_cnt;
    logic [2:0]        lat_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;

    logic view;
    logic step;
    logic unused_view_rise;
    logic unused_btn_lvl;

    mem_view_ctrl_debounce #(.DEB_CNT(DEB_CNT)) u_deb_view (
        .clk        (clk),
        .rst        (rst),
        .din        (sw_view),
        .dout       (view),
        .rise_pulse (unused_view_rise)
    );

    mem_view_ctrl_debounce #(.DEB_CNT(DEB_CNT)) u_deb_next (
        .clk        (clk),
        .rst        (rst),
        .din        (btn_next),
        .dout       (unused_btn_lvl),
        .rise_pulse (step)
    );

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_cnt;
        addr_d  = dbg_addr;
        data_d  = view_data;
        valid_d = view_valid;
        case (state_q)
            S_IDLE: begin
                if (view) state_d = S_SYNC;
            end
            // Freeze only during the low phase so a high phase is never cut short.
            S_SYNC: begin
                if (!view)            state_d = S_IDLE;
                else if (!cpu_clk_lvl) state_d = S_READ;
            end
            // The strobe is already out; a falling view is resolved after the wait.
            S_READ: begin
                state_d = S_WAIT;
                lat_d   = '0;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    if (view) begin
                        state_d = S_SHOW;
                        data_d  = dbg_rdata;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    lat_d = lat_cnt + 3'd1;
                end
            end
            // Leaving the view wins over a coincident step.
            S_SHOW: begin
                if (!view) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (step) begin
                    state_d = S_READ;
                    addr_d  = dbg_addr + 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobe and freeze are registered from the next state so they come
    // straight off flops and line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_cnt     <= '0;
            read_mem_en <= 1'b0;
            dbg_rd      <= 1'b0;
            dbg_addr    <= '0;
            view_data   <= '0;
            view_valid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt     <= lat_d;
            read_mem_en <= (state_d inside {S_READ, S_WAIT, S_SHOW});
            dbg_rd      <= (state_d == S_READ);
            dbg_addr    <= addr_d;
            view_data   <= data_d;
            view_valid  <= valid_d;
        end
    end

endmodule

// File: tb/tb_mem_view_ctrl.sv
// Self-checking bench for mem_view_ctrl (ADDR_W=2, DEB_CNT=3, MEM_LAT=3).
// A transaction-level reference model predicts every output each cycle:
// debounced levels come from a window over the raw input history, and the
// controller is tracked as a mode plus the cycle its read strobe was issued.
module tb_mem_view_ctrl;

    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;
    localparam int DEB_CNT = 3;
    localparam int MEM_LAT = 3;
    localparam int STABLE  = (1 << DEB_CNT) - 1;
    localparam int HIST    = STABLE + 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sw_view;
    logic              btn_next;
    logic              cpu_clk_lvl;
    logic              read_mem_en;
    logic              dbg_rd;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic [DATA_W-1:0] view_data;
    logic              view_valid;

    mem_view_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEB_CNT (DEB_CNT),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_view     (sw_view),
        .btn_next    (btn_next),
        .cpu_clk_lvl (cpu_clk_lvl),
        .read_mem_en (read_mem_en),
        .dbg_rd      (dbg_rd),
        .dbg_addr    (dbg_addr),
        .dbg_rdata   (dbg_rdata),
        .view_data   (view_data),
        .view_valid  (view_valid)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stimulus requested for the next cycle.
    logic sw_raw, btn_raw, lvl_raw, rst_next;

    // Environment: memory contents and a read pipeline whose output is valid
    // only around the clock edge MEM_LAT cycles after the strobe.
    logic [31:0] mem  [DEPTH];
    logic [31:0] pipe [MEM_LAT+1];

    // Reference model.
    typedef enum {M_OFF, M_ARM, M_FETCH, M_DISP} mode_t;
    mode_t             mode;
    int                t_rd;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic [31:0]       m_data;
    bit                deb_sw, deb_btn;
    bit                sw_q[$];
    bit                btn_q[$];

    // True when the oldest STABLE synchronised samples all equal v.
    function automatic bit settled(input bit q[$], input bit v);
        for (int i = 0; i < STABLE; i++)
            if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mode    = M_OFF;
        t_rd    = -100;
        m_addr  = '0;
        m_valid = 1'b0;
        m_data  = '0;
        deb_sw  = 1'b0;
        deb_btn = 1'b0;
        sw_q.delete();
        btn_q.delete();
        for (int i = 0; i < HIST; i++) begin
            sw_q.push_back(1'b0);
            btn_q.push_back(1'b0);
        end
    endtask

    task automatic model_advance(input bit step);
        case (mode)
            M_OFF:   if (deb_sw) mode = M_ARM;
            M_ARM: begin
                if (!deb_sw) mode = M_OFF;
                else if (!lvl_raw) begin
                    mode = M_FETCH;
                    t_rd = cyc + 1;
                end
            end
            M_FETCH: begin
                if (cyc == t_rd + MEM_LAT) begin
                    if (deb_sw) begin
                        mode    = M_DISP;
                        m_valid = 1'b1;
                        m_data  = mem[m_addr];
                    end else begin
                        mode = M_OFF;
                    end
                end
            end
            M_DISP: begin
                if (!deb_sw) begin
                    mode    = M_OFF;
                    m_valid = 1'b0;
                end else if (step) begin
                    m_addr  = m_addr + 1'b1;
                    m_valid = 1'b0;
                    mode    = M_FETCH;
                    t_rd    = cyc + 1;
                end
            end
            default: mode = M_OFF;
        endcase
    endtask

    // One clock cycle: compare at the falling edge, then drive the next inputs.
    task automatic tick();
        bit step;
        @(negedge clk);
        cyc++;
        step = 1'b0;
        if (!rst) begin
            if (settled(sw_q, !deb_sw)) deb_sw = !deb_sw;
            if (settled(btn_q, !deb_btn)) begin
                deb_btn = !deb_btn;
                step    = deb_btn;
            end
        end
        check("read_mem_en", read_mem_en, (mode == M_FETCH || mode == M_DISP));
        check("dbg_rd",      dbg_rd,      (mode == M_FETCH && cyc == t_rd));
        check("dbg_addr",    dbg_addr,    m_addr);
        check("view_valid",  view_valid,  m_valid);
        check("view_data",   view_data,   m_data);
        if (dbg_rd) rd_cnt++;

        rst         = rst_next;
        sw_view     = sw_raw;
        btn_next    = btn_raw;
        cpu_clk_lvl = lvl_raw;
        for (int i = MEM_LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]   = dbg_rd ? mem[dbg_addr] : $urandom;
        dbg_rdata = pipe[MEM_LAT];

        sw_q.push_back(rst ? 1'b0 : sw_raw);
        btn_q.push_back(rst ? 1'b0 : btn_raw);
        void'(sw_q.pop_front());
        void'(btn_q.pop_front());
        if (!rst) model_advance(step);
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_read_mem_en", read_mem_en, 1'b0);
        check("rst_dbg_rd",      dbg_rd,      1'b0);
        check("rst_view_valid",  view_valid,  1'b0);
        check("rst_dbg_addr",    dbg_addr,    '0);
        check("rst_view_data",   view_data,   '0);
        model_reset();
        sw_raw   = 1'b0;
        btn_raw  = 1'b0;
        rst_next = 1'b1;
        repeat (3) tick();
        rst_next = 1'b0;
        tick();
    endtask

    int rd0;

    initial begin
        rst         = 1'b1;
        sw_view     = 1'b0;
        btn_next    = 1'b0;
        cpu_clk_lvl = 1'b1;
        dbg_rdata   = '0;
        sw_raw      = 1'b0;
        btn_raw     = 1'b0;
        lvl_raw     = 1'b1;
        rst_next    = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'hDEAD_BEEF;
        for (int i = 0; i <= MEM_LAT; i++) pipe[i] = $urandom;
        model_reset();

        repeat (3) tick();
        rst_next = 1'b0;
        tick();

        // Bouncing switch, then held high while the CPU clock sits high.
        for (int i = 0; i < 40; i++) begin
            sw_raw = ((i / 3) % 2 == 0);
            tick();
        end
        sw_raw = 1'b1;
        repeat (22) tick();
        check("phase_wait_rme", read_mem_en, 1'b0);

        // CPU clock falls: freeze and read address 0.
        lvl_raw = 1'b0;
        tick();
        check("phase_pre_rme", read_mem_en, 1'b0);
        tick();
        check("phase_rise_rme", read_mem_en, 1'b1);
        check("first_rd", dbg_rd, 1'b1);
        check("first_addr", dbg_addr, 0);
        repeat (MEM_LAT) tick();
        check("lat_valid_early", view_valid, 1'b0);
        tick();
        check("lat_valid", view_valid, 1'b1);
        check("lat_data", view_data, 32'hDEAD_BEEF);

        // Four steps wrap the 2-bit address back to 0.
        rd0 = rd_cnt;
        for (int k = 1; k <= 4; k++) begin
            btn_raw = 1'b1;
            repeat (12) tick();
            btn_raw = 1'b0;
            repeat (12) tick();
            check("wrap_addr", dbg_addr, k % DEPTH);
            check("wrap_rd_count", rd_cnt - rd0, k);
            check("wrap_data", view_data, mem[k % DEPTH]);
        end

        // View falls in the same cycle as a step pulse: step dropped.
        rd0 = rd_cnt;
        sw_raw  = 1'b0;
        btn_raw = 1'b1;
        repeat (12) tick();
        check("coll_addr", dbg_addr, 0);
        check("coll_rd_count", rd_cnt - rd0, 0);
        check("coll_rme", read_mem_en, 1'b0);
        btn_raw = 1'b0;
        repeat (12) tick();

        // Re-enter the view, then drop it while the next read is in flight.
        sw_raw = 1'b1;
        repeat (16) tick();
        check("reenter_valid", view_valid, 1'b1);
        rd0 = rd_cnt;
        btn_raw = 1'b1;
        repeat (2) tick();
        sw_raw = 1'b0;
        repeat (14) tick();
        check("wait_drop_rd_count", rd_cnt - rd0, 1);
        check("wait_drop_valid", view_valid, 1'b0);
        check("wait_drop_rme", read_mem_en, 1'b0);
        check("wait_drop_addr", dbg_addr, 1);
        btn_raw = 1'b0;
        repeat (12) tick();

        // Reset in the middle of a view.
        sw_raw = 1'b1;
        repeat (16) tick();
        check("pre_rst_valid", view_valid, 1'b1);
        async_reset();
        repeat (2) tick();
        check("idle_after_rst", read_mem_en, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) sw_raw = !sw_raw;
            if ($urandom_range(0, 11) == 0) btn_raw = !btn_raw;
            if ($urandom_range(0, 2) == 0)  lvl_raw = !lvl_raw;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
